xpmwrap_sdpram_reader: RTL and testbench
========================================

# xpmwrap_sdpram_reader

Read-side controller for the simple dual-port RAM wrapper. It accepts a burst command (start address, word count) and drives RAM port B (address, enable, output-register clock enable) with the fixed 2-cycle read latency. Returned words go into a small credit-protected output FIFO and leave as a valid/ready stream with a last flag. It sits between the port-B side of a common-clock SDPRAM instance and a downstream stream consumer.

## Interface
- ADDR_WIDTH, 6, RAM port-B address width; burst length range 1..2^ADDR_WIDTH words.
- DATA_WIDTH, 32, RAM port-B read data width and stream data width.
- READ_LATENCY, 2, RAM read latency in cycles; fixed at 2, other values unsupported.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ READ_LATENCY+2.

Ports (name, direction, width, meaning):
- clk  in  1  single clock for block and RAM port B (common_clock mode).
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  ADDR_WIDTH  burst length minus one.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_WIDTH  stream data, FIFO head.
- m_last  out  1  marks final word of burst.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse after last word handshake.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_enb  out  1  RAM read enable.
- ram_regceb  out  1  RAM output register clock enable.
- ram_rstb  out  1  RAM output reset; tied 0.
- ram_doutb  in  DATA_WIDTH  RAM read data.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch addr into read pointer and len into issue counter, latch len into beat counter, go to ISSUE.
- ISSUE: each cycle that credit holds, assert ram_enb with ram_addrb=pointer. Credit means fifo_count + inflight < FIFO_DEPTH. On issue, pointer += 1 modulo 2^ADDR_WIDTH (wraps 63→0 at default). When the read issued has counter=0, go to DRAIN.
- DRAIN: no issues. When the beat with m_last is handshaken, go to IDLE and pulse done.
- Valid pipeline: 2-stage shift register of issue flags plus last flag. ram_regceb = stage-1 flag. At stage 2, ram_doutb is written into the FIFO together with the last flag. inflight = number of set stage flags.
- The FIFO never overflows because credit covers all in-flight reads. There is no stall path into the RAM pipeline.
- m_last is set on the beat whose issue counter was 0. cmd_len=0 gives exactly one beat with m_last=1.
- A handshake occurs when m_valid && m_ready. FIFO push and pop in the same cycle leave the count unchanged.
- Commands are not queued. cmd_valid outside IDLE is ignored (cmd_ready=0).

## Timing
- Reset values (async, immediate):
  - state=IDLE, cmd_ready=1, busy=0, done=0.
  - m_valid=0, m_last=0, m_data=0.
  - ram_enb=0, ram_regceb=0, ram_addrb=0.
  - FIFO empty, pipeline flags cleared.
- Reset mid-burst: the burst is dropped. RAM data still in flight is discarded because the valid flags are cleared.
- Command accepted at edge E0. First ram_enb is in the cycle after E0. That word's data is on ram_doutb 2 cycles later, is pushed at the following edge, and appears as m_valid at E0+4 cycles.
- Throughput: with m_ready held high, 1 word/cycle. An N-word burst ends its last beat at E0+N+3 cycles.
- done is high in the cycle after the last handshake. busy falls in that same cycle. cmd_ready returns to 1 in that same cycle.
- Backpressure: with m_ready low, at most FIFO_DEPTH words are buffered. Issue stalls until credit frees. No data is lost or duplicated.

## Test plan
- Single word: RAM[5]=0xA5A5_0005, cmd addr=5 len=0 → exactly one beat, m_data=0xA5A5_0005, m_last=1, m_valid first at E0+4, done one cycle later.
- Full burst: RAM[i]=i, cmd addr=0 len=63, m_ready=1 → beats 0..63 on 64 consecutive cycles, m_last only on 63, ram_enb high 64 cycles.
- Wrap: cmd addr=62 len=3 → data 62,63,0,1, m_last on 1.
- Backpressure: len=15, m_ready random 30% → 16 beats in order, ram_enb never issued while fifo_count+inflight=4, FIFO never overflows.
- Command while busy: second cmd_valid during burst → cmd_ready=0, ignored. The first burst completes unchanged, and a new command is accepted after done.
- Reset mid-burst: assert rst_n=0 after beat 3 of 8 → all outputs reach reset values immediately. After release, no stale beats appear, and a new cmd addr=10 len=1 returns RAM[10], RAM[11].

Source files
------------

// File: rtl/xpmwrap_sdpram_reader.sv
// ---------------------------------------------------------------------------
// xpmwrap_sdpram_reader
//
// Read-side controller for a common-clock simple dual-port RAM (port B).
// A burst command (start address, length-1) is turned into a run of RAM
// reads with a fixed two-cycle read latency. Returned words are stored in a
// small output FIFO and leave as a valid/ready stream with a last flag.
// Reads are only issued while the FIFO has room for every read already in
// flight, so the RAM pipeline never needs to stall.
//
// Ports:
//   clk, rst_n            clock (shared with RAM port B), async active-low reset
//   cmd_valid/cmd_ready   burst command handshake (ready only while idle)
//   cmd_addr, cmd_len     first word address, burst length minus one
//   m_valid/m_ready       output stream handshake
//   m_data, m_last        output word (FIFO head) and end-of-burst marker
//   busy                  high from command accept until the burst is done
//   done                  one-cycle pulse after the final beat is taken
//   ram_addrb, ram_enb    RAM read address and read enable
//   ram_regceb            RAM output-register clock enable
//   ram_rstb              RAM output-register reset (unused, tied low)
//   ram_doutb             RAM read data
// ---------------------------------------------------------------------------
module xpmwrap_sdpram_reader #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;  // FIFO pointer width
    localparam int CW = $clog2(FIFO_DEPTH + 1);                     // FIFO count width
    localparam int SW = CW + 1;                                     // credit sum width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;              // next RAM address to read
    logic [ADDR_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;  // reads left to issue, minus one
    logic [ADDR_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;    // beats left to deliver, minus one
    logic                    done_q, done_d;

    // Read pipeline: bit 0 is the cycle after issue (RAM output register
    // loading), the top bit is the cycle the word is on ram_doutb.
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] last_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   last_mem_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;

    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    credit;
    logic [SW-1:0]           inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Every read in the pipeline already owns a FIFO slot, so counting them
    // here is what makes the missing stall path safe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + SW'(vld_q[i]);
        end
    end

    assign credit  = (SW'(count_q) + inflight) < SW'(FIFO_DEPTH);
    assign issue   = (state_q == ISSUE) && credit;
    assign push    = vld_q[READ_LATENCY-1];
    assign m_valid = (count_q != '0);
    assign pop     = m_valid && m_ready;

    // NOTE: every variable is given a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;

        if (pop) begin
            beat_cnt_d = beat_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_d       = cmd_addr;
                    issue_cnt_d = cmd_len;
                    beat_cnt_d  = cmd_len;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    ptr_d = ptr_q + 1'b1;  // wraps modulo 2^ADDR_WIDTH
                    if (issue_cnt_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q - 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && (beat_cnt_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            last_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            vld_q       <= {vld_q[READ_LATENCY-2:0], issue};
            last_q      <= {last_q[READ_LATENCY-2:0], issue && (issue_cnt_q == '0)};
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the entries are only read while the
    // (reset) count says they hold data, and the output is gated below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]      <= ram_doutb;
            last_mem_q[wr_ptr_q] <= last_q[READ_LATENCY-1];
        end
    end

    assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_last     = m_valid & last_mem_q[rd_ptr_q];

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    assign ram_addrb  = ptr_q;
    assign ram_enb    = issue;
    assign ram_regceb = vld_q[0];
    assign ram_rstb   = 1'b0;

endmodule

// File: tb/tb_xpmwrap_sdpram_reader.sv
// ---------------------------------------------------------------------------
// Testbench for xpmwrap_sdpram_reader. Includes a behavioural two-cycle
// RAM (address latch + output register) and a burst-level reference: each
// command expands into the list of words RAM[(addr+i) mod 64], i=0..len,
// with the last flag on i=len. Timing expectations are counted in cycles
// from the command handshake cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_xpmwrap_sdpram_reader;

    localparam int AW        = 6;
    localparam int DW        = 32;
    localparam int FD        = 4;
    localparam int RAM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addrb;
    logic          ram_enb;
    logic          ram_regceb;
    logic          ram_rstb;
    logic [DW-1:0] ram_doutb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xpmwrap_sdpram_reader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(2),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .ram_addrb (ram_addrb),
        .ram_enb   (ram_enb),
        .ram_regceb(ram_regceb),
        .ram_rstb  (ram_rstb),
        .ram_doutb (ram_doutb)
    );

    // Behavioural SDPRAM port B: read latched on enb, presented after regce.
    logic [DW-1:0] ram [RAM_WORDS];
    logic [DW-1:0] ram_lat;

    always @(posedge clk) begin
        if (ram_enb)      ram_lat   <= ram[ram_addrb];
        if (ram_rstb)     ram_doutb <= '0;
        else if (ram_regceb) ram_doutb <= ram_lat;
    end

    // Runs one burst from command to done, checking data, order, last flag,
    // addresses, credit and (with m_ready held high) cycle timing.
    // abort_after > 0 returns right after that many beats are accepted.
    task automatic run_burst(input int addr, input int len, input int ready_pct,
                             input bit stray, input int abort_after);
        logic [DW-1:0] exp_d[$];
        bit            exp_l[$];
        logic [DW-1:0] ed;
        bit            el;
        int n, c, issued, hs, last_hs, first_v;
        bit fin;
        n = len + 1;
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(ram[(addr + i) % RAM_WORDS]);
            exp_l.push_back(i == len);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = AW'(len);
        m_ready   = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept addr=%0d: cmd_ready=%b expected 1", addr, cmd_ready);
        end
        issued = 0; hs = 0; last_hs = -1; first_v = -1; fin = 1'b0; c = 0;
        while (!fin) begin
            @(negedge clk);
            c++;
            cmd_valid = stray && (c >= 2) && (c <= 4);
            cmd_addr  = AW'($urandom);
            cmd_len   = AW'($urandom);
            m_ready   = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (last_hs >= 0) begin
                n_checks++;
                if ({done, busy, cmd_ready, m_valid} !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL end_status cycle %0d: done,busy,cmd_ready,m_valid=%b expected 1010",
                             c, {done, busy, cmd_ready, m_valid});
                end
                n_checks++;
                if (issued !== n) begin
                    n_fail++;
                    $display("FAIL issue_total: %0d reads issued, expected %0d", issued, n);
                end
                fin = 1'b1;
            end else begin
                n_checks++;
                if ({done, busy, cmd_ready} !== 3'b010) begin
                    n_fail++;
                    $display("FAIL busy_status cycle %0d: done,busy,cmd_ready=%b expected 010",
                             c, {done, busy, cmd_ready});
                end
                if (ready_pct == 100) begin
                    n_checks++;
                    if (ram_enb !== ((c >= 1) && (c <= n))) begin
                        n_fail++;
                        $display("FAIL enb_window cycle %0d: ram_enb=%b expected %b",
                                 c, ram_enb, (c >= 1) && (c <= n));
                    end
                end
                if (ram_enb === 1'b1) begin
                    n_checks++;
                    if ((issued - hs) >= FD) begin
                        n_fail++;
                        $display("FAIL credit cycle %0d: read issued with %0d words outstanding, limit %0d",
                                 c, issued - hs, FD);
                    end
                    n_checks++;
                    if (ram_addrb !== AW'(addr + issued) || issued >= n) begin
                        n_fail++;
                        $display("FAIL ram_addrb read %0d: got %0d expected %0d (of %0d reads)",
                                 issued, ram_addrb, AW'(addr + issued), n);
                    end
                    issued++;
                end
                if (m_valid === 1'b1 && first_v < 0) begin
                    first_v = c;
                    n_checks++;
                    if (c != 4) begin
                        n_fail++;
                        $display("FAIL first_valid: m_valid first in cycle %0d expected 4", c);
                    end
                end
                if (m_valid === 1'b1 && m_ready === 1'b1) begin
                    n_checks++;
                    if (exp_d.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat cycle %0d: data=%h, no beat expected", c, m_data);
                    end else begin
                        ed = exp_d.pop_front();
                        el = exp_l.pop_front();
                        if (m_data !== ed || m_last !== el) begin
                            n_fail++;
                            $display("FAIL beat %0d: data=%h last=%b expected data=%h last=%b",
                                     hs, m_data, m_last, ed, el);
                        end
                    end
                    hs++;
                    if (hs == n) begin
                        last_hs = c;
                        if (ready_pct == 100) begin
                            n_checks++;
                            if (c != n + 3) begin
                                n_fail++;
                                $display("FAIL last_beat_cycle: cycle %0d expected %0d", c, n + 3);
                            end
                        end
                    end
                    if (abort_after > 0 && hs == abort_after) begin
                        return;
                    end
                end
            end
            if (!fin && c > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: burst addr=%0d len=%0d stuck after %0d beats", addr, len, hs);
                fin = 1'b1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({cmd_ready, busy, done, m_valid, m_last, ram_enb, ram_regceb, ram_rstb} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL %s ctrl: rdy,busy,done,mv,ml,enb,regce,rstb=%b expected 10000000",
                     tag, {cmd_ready, busy, done, m_valid, m_last, ram_enb, ram_regceb, ram_rstb});
        end
        n_checks++;
        if (m_data !== '0 || ram_addrb !== '0) begin
            n_fail++;
            $display("FAIL %s data/addr: m_data=%h ram_addrb=%0d expected 0/0", tag, m_data, ram_addrb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_values("reset_async");
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        ram[5] = 32'hA5A5_0005;
        run_burst(5, 0, 100, 1'b0, 0);
    endtask

    task automatic test_full_burst();
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = DW'(i);
        run_burst(0, 63, 100, 1'b0, 0);
    endtask

    task automatic test_wrap();
        run_burst(62, 3, 100, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = $urandom;
        run_burst(int'($urandom_range(0, RAM_WORDS - 1)), 15, 30, 1'b0, 0);
        run_burst(int'($urandom_range(0, RAM_WORDS - 1)), int'($urandom_range(0, 40)), 50, 1'b0, 0);
    endtask

    task automatic test_cmd_while_busy();
        run_burst(20, 9, 70, 1'b1, 0);
        run_burst(40, 2, 100, 1'b0, 0);
    endtask

    task automatic test_reset_mid_burst();
        run_burst(30, 7, 100, 1'b0, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_burst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (m_valid !== 1'b0 || ram_enb !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_after_reset cycle %0d: m_valid=%b ram_enb=%b busy=%b expected 0",
                         i, m_valid, ram_enb, busy);
            end
        end
        run_burst(10, 1, 100, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_cmd_while_busy();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
